fixed_predictor: RTL and testbench

Reconstructs audio samples for one FLAC FIXED subframe from the decoded residual stream. It sits directly downstream of the residual decoder and consumes one signed 16-bit value per valid strobe. The first `iPredictorOrder` values are warm-up samples, which pass through unchanged. Every later value is a residual, which is added to the fixed-polynomial prediction built from the previous output samples. The reconstructed samples go to the channel decorrelation and output buffer stage.

---
 rtl/flac_pkg.sv | 22 ++
 rtl/fixed_pred_core.sv | 30 +++
 rtl/fixed_predictor.sv | 136 +++++++++++++
 tb/tb_fixed_predictor.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/flac_pkg.sv
// Shared widths, limits and state type for the FLAC subframe decode path.
package flac_pkg;

  localparam int unsigned SAMPLE_W        = 16;
  localparam int unsigned PRED_W          = 20;
  localparam int unsigned MAX_FIXED_ORDER = 4;
  localparam int unsigned ORDER_W         = 4;
  localparam int unsigned COUNT_W         = 16;

  typedef enum logic [2:0] {
    StIdle,
    StWarmup,
    StPredict,
    StDone,
    StErr
  } fp_state_t;

  function automatic logic signed [PRED_W-1:0] sext_sample(logic signed [SAMPLE_W-1:0] s);
    return PRED_W'(s);
  endfunction

endpackage

// File: rtl/fixed_pred_core.sv
// Fixed-polynomial FLAC predictor: combinational, shift-add only.
module fixed_pred_core
  import flac_pkg::*;
(
  input  logic        [ORDER_W-1:0]  order_i,
  input  logic signed [SAMPLE_W-1:0] h1_i,
  input  logic signed [SAMPLE_W-1:0] h2_i,
  input  logic signed [SAMPLE_W-1:0] h3_i,
  input  logic signed [SAMPLE_W-1:0] h4_i,
  output logic signed [PRED_W-1:0]   pred_o
);

  logic signed [PRED_W-1:0] e1, e2, e3, e4;

  always_comb begin
    e1 = sext_sample(h1_i);
    e2 = sext_sample(h2_i);
    e3 = sext_sample(h3_i);
    e4 = sext_sample(h4_i);
    // Worst-case magnitude is 15 * 2^15, which fits in 20 signed bits.
    case (order_i)
      4'd1:    pred_o = e1;
      4'd2:    pred_o = (e1 <<< 1) - e2;
      4'd3:    pred_o = (e1 <<< 1) + e1 - ((e2 <<< 1) + e2) + e3;
      4'd4:    pred_o = (e1 <<< 2) - ((e2 <<< 2) + (e2 <<< 1)) + (e3 <<< 2) - e4;
      default: pred_o = '0;
    endcase
  end

endmodule

// File: rtl/fixed_predictor.sv
// FLAC FIXED subframe reconstruction: warm-up pass-through, then residual + prediction.
module fixed_predictor
  import flac_pkg::*;
(
  input  logic                       iClock,
  input  logic                       iReset,
  input  logic                       iEnable,
  input  logic        [COUNT_W-1:0]  iBlockSize,
  input  logic        [ORDER_W-1:0]  iPredictorOrder,
  input  logic signed [SAMPLE_W-1:0] iResidual,
  input  logic                       iValid,
  output logic signed [SAMPLE_W-1:0] oSample,
  output logic                       oValid,
  output logic                       oDone,
  output logic                       oError
);

  fp_state_t                 state_q, state_d, start_state, eff_state;
  logic [COUNT_W-1:0]        size_q, size_d;
  logic [ORDER_W-1:0]        order_q, order_d;
  logic [COUNT_W-1:0]        count_q, count_d;
  logic [COUNT_W:0]          count_inc;
  logic signed [SAMPLE_W-1:0] h1_q, h2_q, h3_q, h4_q;
  logic signed [SAMPLE_W-1:0] h1_d, h2_d, h3_d, h4_d;
  logic signed [SAMPLE_W-1:0] sample_q, sample_d, sample_new;
  logic                      valid_q, valid_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic                      accept;
  logic signed [PRED_W-1:0]  pred;

  fixed_pred_core u_core (
    .order_i (order_q),
    .h1_i    (h1_q),
    .h2_i    (h2_q),
    .h3_i    (h3_q),
    .h4_i    (h4_q),
    .pred_o  (pred)
  );

  always_comb begin
    if (32'(order_q) > MAX_FIXED_ORDER) begin
      start_state = StErr;
    end else if (size_q == '0) begin
      start_state = StDone;
    end else if (order_q == '0) begin
      start_state = StPredict;
    end else begin
      start_state = StWarmup;
    end
    // IDLE resolves on the same edge it is left, so the first sample is never dropped.
    eff_state = (state_q == StIdle) ? start_state : state_q;
    accept    = iEnable && iValid && (eff_state == StWarmup || eff_state == StPredict);
    count_inc = {1'b0, count_q} + 1'b1;

    if (eff_state == StWarmup) begin
      sample_new = iResidual;
    end else begin
      sample_new = SAMPLE_W'(pred + sext_sample(iResidual));
    end
  end

  always_comb begin
    state_d  = state_q;
    size_d   = size_q;
    order_d  = order_q;
    count_d  = count_q;
    h1_d     = h1_q;
    h2_d     = h2_q;
    h3_d     = h3_q;
    h4_d     = h4_q;
    sample_d = sample_q;
    valid_d  = valid_q;
    done_d   = done_q;
    err_d    = err_q;

    if (iEnable) begin
      valid_d = 1'b0;
      state_d = eff_state;
      err_d   = err_q | (eff_state == StErr);
      done_d  = done_q | (eff_state == StDone);

      if (accept) begin
        sample_d = sample_new;
        valid_d  = 1'b1;
        h4_d     = h3_q;
        h3_d     = h2_q;
        h2_d     = h1_q;
        h1_d     = sample_new;
        count_d  = count_inc[COUNT_W-1:0];
        if (count_inc == {1'b0, size_q}) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else if (eff_state == StWarmup && count_inc == (COUNT_W+1)'(order_q)) begin
          state_d = StPredict;
        end
      end
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q  <= StIdle;
      size_q   <= iBlockSize;
      order_q  <= iPredictorOrder;
      count_q  <= '0;
      h1_q     <= '0;
      h2_q     <= '0;
      h3_q     <= '0;
      h4_q     <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      size_q   <= size_d;
      order_q  <= order_d;
      count_q  <= count_d;
      h1_q     <= h1_d;
      h2_q     <= h2_d;
      h3_q     <= h3_d;
      h4_q     <= h4_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign oSample = sample_q;
  assign oValid  = valid_q;
  assign oDone   = done_q;
  assign oError  = err_q;

endmodule

// File: tb/tb_fixed_predictor.sv
// Bench for fixed_predictor: directed block cases plus randomized blocks against a reference model.
module tb_fixed_predictor;

  logic               iClock = 1'b0;
  logic               iReset = 1'b1;
  logic               iEnable = 1'b1;
  logic [15:0]        iBlockSize = 16'd0;
  logic [3:0]         iPredictorOrder = 4'd0;
  logic signed [15:0] iResidual = 16'sd0;
  logic               iValid = 1'b0;
  logic signed [15:0] oSample;
  logic               oValid, oDone, oError;

  always #5 iClock = ~iClock;

  fixed_predictor dut (
    .iClock          (iClock),
    .iReset          (iReset),
    .iEnable         (iEnable),
    .iBlockSize      (iBlockSize),
    .iPredictorOrder (iPredictorOrder),
    .iResidual       (iResidual),
    .iValid          (iValid),
    .oSample         (oSample),
    .oValid          (oValid),
    .oDone           (oDone),
    .oError          (oError)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(string name, logic signed [31:0] act, logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: binomial-coefficient predictor over a history of past outputs.
  function automatic int pred_of(int k, int h[4]);
    int p = 0;
    int c = 1;
    for (int i = 1; i <= k; i++) begin
      c = c * (k - i + 1) / i;
      p += ((i % 2) == 1) ? c * h[i-1] : -c * h[i-1];
    end
    return p;
  endfunction

  function automatic int wrap16(int v);
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
  endfunction

  int m_size, m_order, m_cnt, m_sample, m_s;
  int m_hist[4];
  bit m_started, m_valid, m_done, m_err;

  initial begin
    m_size = 0; m_order = 0; m_cnt = 0; m_sample = 0; m_s = 0;
    m_hist = '{0, 0, 0, 0};
    m_started = 0; m_valid = 0; m_done = 0; m_err = 0;
    forever begin
      @(posedge iClock);
      if (iReset) begin
        m_size = int'(iBlockSize); m_order = int'(iPredictorOrder);
        m_cnt = 0; m_sample = 0; m_hist = '{0, 0, 0, 0};
        m_started = 0; m_valid = 0; m_done = 0; m_err = 0;
      end else if (iEnable) begin
        m_valid = 0;
        if (!m_started) begin
          m_started = 1;
          if (m_order > 4) m_err = 1;
          else if (m_size == 0) m_done = 1;
        end
        if (iValid && !m_err && !m_done) begin
          if (m_cnt < m_order) m_s = int'(iResidual);
          else m_s = wrap16(pred_of(m_order, m_hist) + int'(iResidual));
          m_hist[3] = m_hist[2]; m_hist[2] = m_hist[1]; m_hist[1] = m_hist[0];
          m_hist[0] = m_s;
          m_cnt++;
          m_valid = 1;
          m_sample = m_s;
          if (m_cnt == m_size) m_done = 1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge iClock);
      if (chk_en) begin
        check("oValid", 32'(oValid), 32'(m_valid));
        check("oSample", 32'(oSample), m_sample);
        check("oDone", 32'(oDone), 32'(m_done));
        check("oError", 32'(oError), 32'(m_err));
      end
    end
  end

  int cap_q[$];
  bit capd_q[$];

  initial begin
    forever begin
      @(negedge iClock);
      if (oValid === 1'b1) begin
        cap_q.push_back(int'(oSample));
        capd_q.push_back(oDone);
      end
    end
  end

  task automatic tick();
    @(posedge iClock);
    #2;
  endtask

  task automatic do_reset(int o, int s);
    iReset = 1'b1; iEnable = 1'b1; iValid = 1'b0;
    iPredictorOrder = 4'(o); iBlockSize = 16'(s);
    tick();
    chk_en = 1'b1;
    tick();
    iReset = 1'b0;
    cap_q.delete();
    capd_q.delete();
  endtask

  task automatic feed(int v);
    iValid = 1'b1;
    iResidual = 16'(v);
    tick();
    iValid = 1'b0;
  endtask

  task automatic expect_outs(string name, int n, int e[8]);
    check({name, "_count"}, cap_q.size(), n);
    for (int i = 0; i < n && i < cap_q.size(); i++) check(name, cap_q[i], e[i]);
    if (cap_q.size() == n && n > 0) check({name, "_done_last"}, 32'(capd_q[n-1]), 1);
    if (cap_q.size() == n && n > 1) check({name, "_done_early"}, 32'(capd_q[n-2]), 0);
  endtask

  initial begin
    int v;
    do_reset(0, 4);
    check("reset_sample", 32'(oSample), 0);
    check("reset_done", 32'(oDone), 0);
    feed(5); feed(-3); feed(7); feed(0); tick();
    expect_outs("ord0", 4, '{5, -3, 7, 0, 0, 0, 0, 0});

    do_reset(1, 4);
    feed(100); feed(1); feed(1); feed(1); tick();
    expect_outs("ord1", 4, '{100, 101, 102, 103, 0, 0, 0, 0});

    do_reset(4, 6);
    feed(0); feed(1); feed(8); feed(27); feed(0); feed(0); tick();
    expect_outs("cubic", 6, '{0, 1, 8, 27, 64, 125, 0, 0});

    do_reset(1, 2);
    feed(32767); feed(1); tick();
    expect_outs("wrap", 2, '{32767, -32768, 0, 0, 0, 0, 0, 0});
    check("wrap_err", 32'(oError), 0);

    do_reset(5, 4);
    tick();
    check("err_rise", 32'(oError), 1);
    feed(1); feed(2); tick();
    check("err_no_valid", cap_q.size(), 0);
    do_reset(2, 3);
    feed(10); feed(20); feed(0); tick();
    expect_outs("after_err", 3, '{10, 20, 30, 0, 0, 0, 0, 0});

    do_reset(2, 8);
    feed(10); feed(20); feed(5);
    iReset = 1'b1; iValid = 1'b1; iResidual = 16'sd99;
    iPredictorOrder = 4'd0; iBlockSize = 16'd1;
    tick();
    iValid = 1'b0;
    tick();
    check("midrst_count", cap_q.size(), 3);
    if (cap_q.size() == 3) check("midrst_third", cap_q[2], 35);
    check("midrst_done", 32'(oDone), 0);
    iReset = 1'b0;
    cap_q.delete(); capd_q.delete();
    feed(9); tick();
    expect_outs("restart", 1, '{9, 0, 0, 0, 0, 0, 0, 0});

    // Randomized blocks with enable gaps, sparse strobes and occasional mid-block reset.
    for (int b = 0; b < 40; b++) begin
      bit big;
      big = ($urandom % 2) == 1;
      if ($urandom % 8 == 0) do_reset(int'($urandom_range(5, 15)), int'($urandom_range(0, 12)));
      else do_reset(int'($urandom_range(0, 4)), int'($urandom_range(0, 14)));
      for (int c = 0; c < 30; c++) begin
        iEnable = ($urandom % 5) != 0;
        iValid = ($urandom % 4) != 0;
        if (big) v = int'($urandom_range(0, 65535)) - 32768;
        else v = int'($urandom_range(0, 200)) - 100;
        iResidual = 16'(v);
        iReset = ($urandom % 60) == 0;
        if (iReset) begin
          iPredictorOrder = 4'($urandom_range(0, 5));
          iBlockSize = 16'($urandom_range(0, 10));
        end
        tick();
      end
      iReset = 1'b0; iValid = 1'b0; iEnable = 1'b1;
    end

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
